// File: rtl/logic1_pkg.sv
// Shared types and constants for the logic1 evaluator and its round-robin front end.
`timescale 1ns/1ps
package logic1_pkg;

  localparam int X_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EVAL = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/logic1_eval.sv
// Purely combinational 2-bit logic1 evaluator: X1X2 -> Z1Z2 (00->10, 01->00, 10->01, 11->11).
`timescale 1ns/1ps
module logic1_eval
  import logic1_pkg::*;
(
  input  logic [X_W-1:0] x,
  output logic           z1,
  output logic           z2
);

  logic s2;

  assign s2 = x[1] ^ x[0];
  assign z1 = ~s2;
  assign z2 = (x[1] & x[0] & ~s2) | (x[1] & ~x[0] & s2);

endmodule

// File: rtl/logic1_share_arb.sv
// Round-robin arbiter sharing one logic1_eval between N_REQ requesters; IDLE -> EVAL -> RESP.
`timescale 1ns/1ps
module logic1_share_arb
  import logic1_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [X_W*N_REQ-1:0]   req_x,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic                   resp_z1,
  output logic                   resp_z2,
  output logic                   busy,
  output logic [CNT_W-1:0]       done_cnt
);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;
  logic             resp_z1_q, resp_z1_d;
  logic             resp_z2_q, resp_z2_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic             grant_any;
  logic [ID_W-1:0]  grant_idx;
  logic             eval_z1, eval_z2;

  logic1_eval u_eval (
    .x  (x_q),
    .z1 (eval_z1),
    .z2 (eval_z2)
  );

  // Search starts one past the last served requester so grants rotate.
  always_comb begin
    int cand;
    cand      = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last_grant_q) + k) % N_REQ;
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    x_d          = x_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_z1_d    = resp_z1_q;
    resp_z2_d    = resp_z2_q;
    done_cnt_d   = done_cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          x_d     = req_x[X_W*int'(grant_idx) +: X_W];
          id_d    = grant_idx;
          state_d = EVAL;
        end
      end
      EVAL: begin
        resp_z1_d    = eval_z1;
        resp_z2_d    = eval_z2;
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          last_grant_d = id_q;
          done_cnt_d   = done_cnt_q + CNT_W'(1);
          state_d      = IDLE;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(N_REQ - 1);
      x_q          <= '0;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_z1_q    <= 1'b0;
      resp_z2_q    <= 1'b0;
      done_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      x_q          <= x_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_z1_q    <= resp_z1_d;
      resp_z2_q    <= resp_z2_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_z1    = resp_z1_q;
  assign resp_z2    = resp_z2_q;
  assign done_cnt   = done_cnt_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_logic1_share_arb.sv
// Directed bench for logic1_share_arb: reset, truth table, fairness, backpressure, mid-op reset, wrap.
`timescale 1ns/1ps
module tb_logic1_share_arb;

  localparam int N_REQ = 2;
  localparam int ID_W  = 1;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_REQ-1:0] req_valid;
  logic [2*N_REQ-1:0] req_x;
  logic [N_REQ-1:0] req_ready;
  logic             resp_valid;
  logic             resp_ready;
  logic [ID_W-1:0]  resp_id;
  logic             resp_z1;
  logic             resp_z2;
  logic             busy;
  logic [CNT_W-1:0] done_cnt;

  int               n_chk  = 0;
  int               n_fail = 0;
  logic [CNT_W-1:0] exp_cnt;

  logic1_share_arb #(.N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_z1    (resp_z1),
    .resp_z2    (resp_z2),
    .busy       (busy),
    .done_cnt   (done_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand truth table, returns {Z1,Z2}
  function automatic logic [1:0] zexp(input logic [1:0] x);
    case (x)
      2'b00:   zexp = 2'b10;
      2'b01:   zexp = 2'b00;
      2'b10:   zexp = 2'b01;
      default: zexp = 2'b11;
    endcase
  endfunction

  // One full transaction from IDLE, with bp cycles of resp_ready=0 in RESP.
  task automatic txn(input string tag, input logic [1:0] vld, input logic [3:0] x,
                     input logic [1:0] exp_rdy, input int exp_id, input logic [1:0] exp_z,
                     input int bp);
    req_valid  = vld;
    req_x      = x;
    resp_ready = (bp == 0);
    #1;
    check({tag, "_req_ready"}, 32'(req_ready), 32'(exp_rdy));
    tick();
    check({tag, "_eval_busy"}, 32'(busy), 32'd1);
    check({tag, "_eval_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_eval_valid"}, 32'(resp_valid), 32'd0);
    tick();
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_resp_id"}, 32'(resp_id), 32'(exp_id));
    check({tag, "_resp_z"}, 32'({resp_z1, resp_z2}), 32'(exp_z));
    for (int i = 0; i < bp; i++) begin
      tick();
      check({tag, "_bp_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_bp_hold"}, 32'({resp_id, resp_z1, resp_z2}), 32'({exp_id[0], exp_z}));
      check({tag, "_bp_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_bp_cnt"}, 32'(done_cnt), 32'(exp_cnt));
    end
    resp_ready = 1'b1;
    tick();
    exp_cnt++;
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
    check({tag, "_done_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_cnt));
  endtask

  task automatic do_reset(input int cycles);
    rst_n     = 1'b0;
    req_valid = '1;
    repeat (cycles) tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_done_cnt", 32'(done_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_fields", 32'({resp_id, resp_z1, resp_z2}), 32'd0);
    rst_n   = 1'b1;
    exp_cnt = '0;
  endtask

  initial begin
    logic [1:0] xv;
    rst_n      = 1'b0;
    req_valid  = '1;
    req_x      = '0;
    resp_ready = 1'b0;
    exp_cnt    = '0;

    // T1 reset
    do_reset(3);

    // T2 truth table through requester 0
    for (int v = 0; v < 4; v++) begin
      xv = 2'(v);
      txn("t2", 2'b01, {2'b00, xv}, 2'b01, 0, zexp(xv), 0);
    end

    // T3 fairness from a fresh reset
    do_reset(1);
    for (int n = 0; n < 4; n++) begin
      if (n % 2 == 0) txn("t3", 2'b11, {2'b11, 2'b01}, 2'b01, 0, 2'b00, 0);
      else            txn("t3", 2'b11, {2'b11, 2'b01}, 2'b10, 1, 2'b11, 0);
    end
    check("t3_cnt4", 32'(done_cnt), 32'd4);

    // T4 backpressure
    txn("t4", 2'b01, {2'b00, 2'b10}, 2'b01, 0, 2'b01, 5);

    // T5 reset while in EVAL; last grant was 0 so only a restored pointer favours req0
    req_valid  = 2'b10;
    req_x      = {2'b10, 2'b00};
    resp_ready = 1'b1;
    #1;
    check("t5_grant1", 32'(req_ready), 32'b10);
    tick();
    check("t5_in_eval", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    exp_cnt   = '0;
    req_valid = '0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_cnt", 32'(done_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_resp", 32'(resp_valid), 32'd0);
    end
    req_valid = 2'b11;
    #1;
    check("t5_req0_wins", 32'(req_ready), 32'b01);

    // T6 counter wrap with 4-bit counter
    for (int n = 0; n < 17; n++) begin
      xv = 2'(n % 4);
      if (n % 2 == 0) txn("t6", 2'b11, {xv, xv}, 2'b01, 0, zexp(xv), 0);
      else            txn("t6", 2'b11, {xv, xv}, 2'b10, 1, zexp(xv), 0);
    end
    check("t6_wrap", 32'(done_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
